// File: rtl/jedro_1_defines.sv
// Shared definitions for the core-local interruptor: register offsets,
// reset constants and the byte-enable merge used by all bus writes.
package jedro_1_defines;

  localparam int unsigned CLINT_BUS_BE_WIDTH = 4;

  localparam logic [7:0] CLINT_ADDR_MSIP        = 8'h00;
  localparam logic [7:0] CLINT_ADDR_MTIMECMP_LO = 8'h08;
  localparam logic [7:0] CLINT_ADDR_MTIMECMP_HI = 8'h0C;
  localparam logic [7:0] CLINT_ADDR_MTIME_LO    = 8'h10;
  localparam logic [7:0] CLINT_ADDR_MTIME_HI    = 8'h14;

  localparam logic [63:0] CLINT_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    CLINT_REG_MSIP,
    CLINT_REG_MTIMECMP_LO,
    CLINT_REG_MTIMECMP_HI,
    CLINT_REG_MTIME_LO,
    CLINT_REG_MTIME_HI,
    CLINT_REG_NONE
  } clint_reg_e;

  // Replaces only the bytes selected by be, keeping the rest of old_v.
  function automatic logic [31:0] clint_be_merge(input logic [31:0] old_v,
                                                 input logic [31:0] new_v,
                                                 input logic [CLINT_BUS_BE_WIDTH-1:0] be);
    logic [31:0] merged;
    merged = old_v;
    for (int i = 0; i < CLINT_BUS_BE_WIDTH; i++) begin
      if (be[i]) merged[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/jedro_1_clint_prescaler.sv
// Tick generator for mtime: counts 0..PRESCALER-1 and asserts tick_o while
// the count sits at its last value, so PRESCALER=1 ticks every cycle.
module jedro_1_clint_prescaler #(
  parameter int unsigned PRESCALER = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int unsigned CntW = (PRESCALER > 1) ? $clog2(PRESCALER) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(PRESCALER - 1);

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  assign tick_o = (cnt_q == CntMax);
  assign cnt_d  = tick_o ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/jedro_1_clint.sv
// Core-local interruptor: mtime/mtimecmp/msip behind a single-cycle bus slave,
// driving the level timer and software interrupt lines toward the core.
module jedro_1_clint
  import jedro_1_defines::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned PRESCALER  = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          req_i,
  input  logic                          we_i,
  input  logic [CLINT_BUS_BE_WIDTH-1:0] be_i,
  input  logic [ADDR_WIDTH-1:0]         addr_i,
  input  logic [DATA_WIDTH-1:0]         wdata_i,
  output logic                          rvalid_o,
  output logic [DATA_WIDTH-1:0]         rdata_o,
  output logic                          err_o,
  output logic                          timer_irq_o,
  output logic                          sw_irq_o
);

  clint_reg_e            reg_sel;
  logic                  addr_err;
  logic                  wr_en;
  logic                  tick;
  logic [DATA_WIDTH-1:0] rd_val;

  logic [63:0]           mtime_q, mtime_d;
  logic [63:0]           mtimecmp_q, mtimecmp_d;
  logic                  msip_q, msip_d;
  logic                  timer_irq_q, timer_irq_d;
  logic                  rvalid_q, rvalid_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  jedro_1_clint_prescaler #(
    .PRESCALER (PRESCALER)
  ) u_prescaler (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .tick_o (tick)
  );

  always_comb begin
    reg_sel = CLINT_REG_NONE;
    if (addr_i[1:0] == 2'b00) begin
      case (addr_i)
        ADDR_WIDTH'(CLINT_ADDR_MSIP):        reg_sel = CLINT_REG_MSIP;
        ADDR_WIDTH'(CLINT_ADDR_MTIMECMP_LO): reg_sel = CLINT_REG_MTIMECMP_LO;
        ADDR_WIDTH'(CLINT_ADDR_MTIMECMP_HI): reg_sel = CLINT_REG_MTIMECMP_HI;
        ADDR_WIDTH'(CLINT_ADDR_MTIME_LO):    reg_sel = CLINT_REG_MTIME_LO;
        ADDR_WIDTH'(CLINT_ADDR_MTIME_HI):    reg_sel = CLINT_REG_MTIME_HI;
        default:                             reg_sel = CLINT_REG_NONE;
      endcase
    end
  end

  assign addr_err = (reg_sel == CLINT_REG_NONE);
  // A write with no byte enables is a plain no-op, so it must not block the tick.
  assign wr_en    = req_i && we_i && !addr_err && (be_i != '0);

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      CLINT_REG_MSIP:        rd_val[0] = msip_q;
      CLINT_REG_MTIMECMP_LO: rd_val = mtimecmp_q[31:0];
      CLINT_REG_MTIMECMP_HI: rd_val = mtimecmp_q[63:32];
      CLINT_REG_MTIME_LO:    rd_val = mtime_q[31:0];
      CLINT_REG_MTIME_HI:    rd_val = mtime_q[63:32];
      default:               rd_val = '0;
    endcase
  end

  always_comb begin
    rvalid_d = req_i;
    err_d    = req_i && addr_err;
    rdata_d  = (req_i && !we_i && !addr_err) ? rd_val : '0;
  end

  // A write to either mtime half overrides the tick; the other half holds.
  always_comb begin
    mtime_d     = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d  = mtimecmp_q;
    msip_d      = msip_q;
    timer_irq_d = (mtime_q >= mtimecmp_q);
    if (wr_en) begin
      case (reg_sel)
        CLINT_REG_MSIP:        if (be_i[0]) msip_d = wdata_i[0];
        CLINT_REG_MTIMECMP_LO: mtimecmp_d[31:0]  = clint_be_merge(mtimecmp_q[31:0], wdata_i, be_i);
        CLINT_REG_MTIMECMP_HI: mtimecmp_d[63:32] = clint_be_merge(mtimecmp_q[63:32], wdata_i, be_i);
        CLINT_REG_MTIME_LO:    mtime_d = {mtime_q[63:32], clint_be_merge(mtime_q[31:0], wdata_i, be_i)};
        CLINT_REG_MTIME_HI:    mtime_d = {clint_be_merge(mtime_q[63:32], wdata_i, be_i), mtime_q[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtime_q     <= '0;
      mtimecmp_q  <= CLINT_MTIMECMP_RST;
      msip_q      <= 1'b0;
      timer_irq_q <= 1'b0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      timer_irq_q <= timer_irq_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

  assign rvalid_o    = rvalid_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign timer_irq_o = timer_irq_q;
  assign sw_irq_o    = msip_q;

endmodule

// File: tb/tb_jedro_1_clint.sv
// Self-checking bench for jedro_1_clint: two instances (PRESCALER 4 and 1)
// share one bus driver; responses are checked against a scoreboard queue.
module tb_jedro_1_clint;
  import jedro_1_defines::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        req = 1'b0;
  logic        we  = 1'b0;
  logic [3:0]  be  = 4'h0;
  logic [4:0]  addr  = 5'h0;
  logic [31:0] wdata = 32'h0;

  logic        req_p4, req_p1;
  logic        rvalid_p4, err_p4, tirq_p4, sirq_p4;
  logic        rvalid_p1, err_p1, tirq_p1, sirq_p1;
  logic [31:0] rdata_p4, rdata_p1;
  logic        rvalid_m, err_m;
  logic [31:0] rdata_m;

  assign req_p4   = req & ~sel;
  assign req_p1   = req &  sel;
  assign rvalid_m = sel ? rvalid_p1 : rvalid_p4;
  assign err_m    = sel ? err_p1    : err_p4;
  assign rdata_m  = sel ? rdata_p1  : rdata_p4;

  always #5 clk = ~clk;

  jedro_1_clint #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .PRESCALER(4)) u_dut_p4 (
    .clk_i(clk), .rst_i(rst), .req_i(req_p4), .we_i(we), .be_i(be), .addr_i(addr),
    .wdata_i(wdata), .rvalid_o(rvalid_p4), .rdata_o(rdata_p4), .err_o(err_p4),
    .timer_irq_o(tirq_p4), .sw_irq_o(sirq_p4));

  jedro_1_clint #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .PRESCALER(1)) u_dut_p1 (
    .clk_i(clk), .rst_i(rst), .req_i(req_p1), .we_i(we), .be_i(be), .addr_i(addr),
    .wdata_i(wdata), .rvalid_o(rvalid_p1), .rdata_o(rdata_p1), .err_o(err_p1),
    .timer_irq_o(tirq_p1), .sw_irq_o(sirq_p1));

  // Reference model, index 0 = PRESCALER 4 instance, 1 = PRESCALER 1 instance.
  logic [63:0] m_mtime [2];
  logic [63:0] m_cmp   [2];
  logic        m_msip  [2];
  int          m_cnt   [2];
  logic        m_tick;
  logic [63:0] m_nt;

  function automatic int presc(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic logic is_err(input logic [4:0] a);
    return !(a inside {5'h00, 5'h08, 5'h0C, 5'h10, 5'h14});
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = b[i] ? n[i*8 +: 8] : o[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input int d, input logic [4:0] a);
    case (a)
      5'h00:   return {31'h0, m_msip[d]};
      5'h08:   return m_cmp[d][31:0];
      5'h0C:   return m_cmp[d][63:32];
      5'h10:   return m_mtime[d][31:0];
      5'h14:   return m_mtime[d][63:32];
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_mtime[d] = 64'h0;
        m_cmp[d]   = 64'hFFFF_FFFF_FFFF_FFFF;
        m_msip[d]  = 1'b0;
        m_cnt[d]   = 0;
      end else begin
        m_tick   = (m_cnt[d] == presc(d) - 1);
        m_cnt[d] = m_tick ? 0 : m_cnt[d] + 1;
        m_nt     = m_tick ? m_mtime[d] + 64'd1 : m_mtime[d];
        if (req && we && ((sel ? 1 : 0) == d) && !is_err(addr) && (be != 4'h0)) begin
          case (addr)
            5'h00: if (be[0]) m_msip[d] = wdata[0];
            5'h08: m_cmp[d][31:0]  = merge(m_cmp[d][31:0], wdata, be);
            5'h0C: m_cmp[d][63:32] = merge(m_cmp[d][63:32], wdata, be);
            5'h10: m_nt = {m_mtime[d][63:32], merge(m_mtime[d][31:0], wdata, be)};
            5'h14: m_nt = {merge(m_mtime[d][63:32], wdata, be), m_mtime[d][31:0]};
            default: ;
          endcase
        end
        m_mtime[d] = m_nt;
      end
    end
  end

  // Response monitor: rvalid must follow each request by one cycle and
  // carry the scoreboard's expected data.
  logic req_sent, rst_edge;
  always @(posedge clk) begin
    req_sent = sel ? req_p1 : req_p4;
    rst_edge = rst;
    #2;
    if (rst || rst_edge) begin
      sb.delete();
    end else begin
      if (rvalid_m || req_sent) begin
        n_checks++;
        if (rvalid_m !== req_sent) begin
          n_fail++;
          $display("[TB] FAIL rvalid_timing: rvalid=%b expected %b at %0t", rvalid_m, req_sent, $time);
        end
      end
      if (rvalid_m === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL unexpected_response: rvalid with empty scoreboard at %0t", $time);
        end else begin
          mon_e = sb.pop_front();
          if (rdata_m !== mon_e.rdata || err_m !== mon_e.err) begin
            n_fail++;
            $display("[TB] FAIL %s: rdata=%h err=%b expected rdata=%h err=%b", mon_e.name,
                     rdata_m, err_m, mon_e.rdata, mon_e.err);
          end
        end
      end
    end
  end

  task automatic drive(input logic w, input logic [3:0] b, input logic [4:0] a, input logic [31:0] wd);
    req = 1'b1; we = w; be = b; addr = a; wdata = wd;
  endtask

  task automatic bus(input logic w, input logic [3:0] b, input logic [4:0] a, input logic [31:0] wd,
                     input string nm);
    exp_t e;
    drive(w, b, a, wd);
    e.err   = is_err(a);
    e.rdata = (!w && !e.err) ? model_read(sel ? 1 : 0, a) : 32'h0;
    e.name  = nm;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic bus_exp(input logic w, input logic [3:0] b, input logic [4:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input string nm);
    exp_t e;
    drive(w, b, a, wd);
    e.err   = is_err(a);
    e.rdata = exp_rd;
    e.name  = nm;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req = 1'b0; we = 1'b0; be = 4'h0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    req = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    sel = 1'b1;
    req = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({rvalid_p4, rdata_p4, err_p4, tirq_p4, sirq_p4, rvalid_p1, rdata_p1, err_p1, tirq_p1, sirq_p1} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: p4=%b/%h/%b/%b/%b p1=%b/%h/%b/%b/%b expected all zero",
               rvalid_p4, rdata_p4, err_p4, tirq_p4, sirq_p4, rvalid_p1, rdata_p1, err_p1, tirq_p1, sirq_p1);
    end
    rst = 1'b0;
    bus_exp(1'b0, 4'h0, 5'h10, 32'h0, 32'h0000_0000, "mtime_lo_after_reset");
    bus_exp(1'b0, 4'h0, 5'h08, 32'h0, 32'hFFFF_FFFF, "mtimecmp_lo_reset");
    bus_exp(1'b0, 4'h0, 5'h0C, 32'h0, 32'hFFFF_FFFF, "mtimecmp_hi_reset");
    idle(1);
    n_checks++;
    if ({tirq_p4, sirq_p4, tirq_p1, sirq_p1} !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL irq_after_reset: got %b expected 0000", {tirq_p4, sirq_p4, tirq_p1, sirq_p1});
    end
  endtask

  task automatic test_prescaler;
    sel = 1'b0;
    do_reset();
    repeat (40) @(negedge clk);
    bus_exp(1'b0, 4'h0, 5'h10, 32'h0, 32'd10, "mtime_lo_presc4_40cyc");
    bus_exp(1'b0, 4'h0, 5'h14, 32'h0, 32'd0, "mtime_hi_presc4");
    for (int i = 0; i < 6; i++) bus(1'b0, 4'h0, 5'h10, 32'h0, "mtime_lo_presc4_run");
    idle(1);
    sel = 1'b1;
    bus(1'b0, 4'h0, 5'h10, 32'h0, "mtime_lo_presc1_run");
    idle(1);
  endtask

  task automatic test_timer_irq;
    sel = 1'b1;
    bus(1'b1, 4'hF, 5'h10, 32'd0, "wr_mtime_lo_zero");
    bus(1'b1, 4'hF, 5'h0C, 32'd0, "wr_cmp_hi_zero");
    bus(1'b1, 4'hF, 5'h08, 32'd20, "wr_cmp_lo_20");
    for (int k = 3; k <= 25; k++) begin
      idle(1);
      n_checks++;
      if (tirq_p1 !== (k >= 21)) begin
        n_fail++;
        $display("[TB] FAIL timer_rise: cycle %0d irq=%b expected %b", k, tirq_p1, (k >= 21));
      end
    end
    bus(1'b1, 4'hF, 5'h08, 32'hFFFF_FFFF, "wr_cmp_lo_max");
    n_checks++;
    if (tirq_p1 !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL timer_hold: irq=%b expected 1", tirq_p1);
    end
    idle(1);
    n_checks++;
    if (tirq_p1 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL timer_fall: irq=%b expected 0", tirq_p1);
    end
  endtask

  task automatic test_mtime_wrap;
    sel = 1'b1;
    bus(1'b1, 4'hF, 5'h10, 32'hFFFF_FFFF, "wr_mtime_lo_max");
    bus(1'b1, 4'hF, 5'h14, 32'h0, "wr_mtime_hi_zero");
    idle(1);
    bus_exp(1'b0, 4'h0, 5'h14, 32'h0, 32'd1, "mtime_hi_after_wrap");
    bus(1'b0, 4'h0, 5'h10, 32'h0, "mtime_lo_after_wrap");
    bus(1'b1, 4'hF, 5'h10, 32'd5, "wr_mtime_lo_5_on_tick");
    bus_exp(1'b0, 4'h0, 5'h10, 32'h0, 32'd5, "mtime_lo_write_wins");
    bus_exp(1'b0, 4'h0, 5'h14, 32'h0, 32'd1, "mtime_hi_held");
    idle(1);
  endtask

  task automatic test_msip;
    sel = 1'b1;
    n_checks++;
    if (sirq_p1 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL sw_irq_idle: got %b expected 0", sirq_p1);
    end
    bus(1'b1, 4'b0001, 5'h00, 32'hFFFF_FFFF, "wr_msip_set");
    n_checks++;
    if (sirq_p1 !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL sw_irq_set: got %b expected 1", sirq_p1);
    end
    bus_exp(1'b0, 4'h0, 5'h00, 32'h0, 32'h0000_0001, "rd_msip_set");
    bus(1'b1, 4'b0010, 5'h00, 32'h0, "wr_msip_be_hi_only");
    bus_exp(1'b0, 4'h0, 5'h00, 32'h0, 32'h0000_0001, "rd_msip_unchanged");
    idle(1);
    n_checks++;
    if (sirq_p1 !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL sw_irq_hold: got %b expected 1", sirq_p1);
    end
    bus(1'b1, 4'b0001, 5'h00, 32'h0, "wr_msip_clear");
    idle(1);
    n_checks++;
    if (sirq_p1 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL sw_irq_clear: got %b expected 0", sirq_p1);
    end
  endtask

  task automatic test_errors;
    sel = 1'b0;
    bus_exp(1'b0, 4'h0, 5'h04, 32'h0, 32'h0, "rd_unmapped_04");
    bus(1'b1, 4'hF, 5'h11, 32'h0, "wr_misaligned_11");
    bus(1'b0, 4'h0, 5'h10, 32'h0, "mtime_lo_after_err_wr");
    bus(1'b1, 4'hF, 5'h09, 32'h0, "wr_misaligned_09");
    bus(1'b0, 4'h0, 5'h08, 32'h0, "cmp_lo_after_err_wr");
    bus(1'b0, 4'h0, 5'h18, 32'h0, "rd_unmapped_18");
    bus(1'b0, 4'h0, 5'h1E, 32'h0, "rd_misaligned_1e");
    idle(1);
  endtask

  task automatic test_back_to_back;
    logic [4:0] regs [5];
    regs = '{5'h00, 5'h08, 5'h0C, 5'h10, 5'h14};
    sel = 1'b0;
    bus(1'b1, 4'b0100, 5'h08, 32'h00AB_CDEF, "wr_cmp_lo_byte2");
    bus(1'b1, 4'b0000, 5'h0C, 32'h1234_5678, "wr_cmp_hi_no_be");
    bus(1'b1, 4'b1001, 5'h0C, 32'h1234_5678, "wr_cmp_hi_bytes03");
    for (int i = 0; i < 5; i++) bus(1'b0, 4'h0, regs[i], 32'h0, "b2b_read");
    bus_exp(1'b0, 4'h0, 5'h08, 32'h0, 32'hFFAB_FFFF, "cmp_lo_merged");
    bus_exp(1'b0, 4'h0, 5'h0C, 32'h0, 32'h12FF_FF78, "cmp_hi_merged");
    idle(1);
  endtask

  task automatic test_reset_midxfer;
    sel = 1'b1;
    bus(1'b1, 4'b0001, 5'h00, 32'h1, "wr_msip_pre_rst");
    bus(1'b1, 4'hF, 5'h0C, 32'h0, "wr_cmp_hi_pre_rst");
    bus(1'b1, 4'hF, 5'h08, 32'h0, "wr_cmp_lo_pre_rst");
    bus(1'b0, 4'h0, 5'h10, 32'h0, "rd_mtime_pre_rst");
    n_checks++;
    if ({rvalid_p1, tirq_p1, sirq_p1} !== 3'b111) begin
      n_fail++;
      $display("[TB] FAIL pre_reset_state: rvalid/tirq/sirq=%b expected 111", {rvalid_p1, tirq_p1, sirq_p1});
    end
    drive(1'b0, 4'h0, 5'h00, 32'h0);
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({rvalid_p1, rdata_p1, err_p1, tirq_p1, sirq_p1} !== '0) begin
      n_fail++;
      $display("[TB] FAIL async_reset: rvalid=%b rdata=%h err=%b tirq=%b sirq=%b expected all zero",
               rvalid_p1, rdata_p1, err_p1, tirq_p1, sirq_p1);
    end
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (rvalid_p1 !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL dropped_response: rvalid=%b expected 0", rvalid_p1);
      end
    end
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_prescaler();
    test_timer_irq();
    test_mtime_wrap();
    test_msip();
    test_errors();
    test_back_to_back();
    test_reset_midxfer();
    idle(3);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL missing_responses: %0d outstanding expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jedro_1_clint.md
Name: jedro_1_clint

Overview:
- Core-local interruptor: the source end of the interrupt lines that the CSR block samples into MIP.
- Holds a 64-bit free-running mtime, a 64-bit mtimecmp and a software-interrupt bit.
- Drives timer_irq_o and sw_irq_o toward the core.
- Memory-mapped on the LSU data bus through a simple single-cycle request/response slave port.

Parameters:
- DATA_WIDTH, 32, bus data width; only 32 is supported.
- ADDR_WIDTH, 5, byte-offset width of the register window.
- PRESCALER, 1, clock cycles per mtime tick; must be >= 1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- req_i  in  1  bus request, one transfer per asserted cycle
- we_i  in  1  1 = write, 0 = read
- be_i  in  4  byte enables for writes
- addr_i  in  ADDR_WIDTH  byte offset within the window
- wdata_i  in  DATA_WIDTH  write data
- rvalid_o  out  1  response valid, exactly one per request
- rdata_o  out  DATA_WIDTH  read data, valid with rvalid_o
- err_o  out  1  bus error, valid with rvalid_o
- timer_irq_o  out  1  machine timer interrupt, level
- sw_irq_o  out  1  machine software interrupt, level

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (clk_i, rst_i). Reset values:
  - rvalid_o=0, rdata_o=0, err_o=0, timer_irq_o=0, sw_irq_o=0.
  - mtime=0, prescaler count=0, msip=0.
  - mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, so no interrupt after reset.
- Reset mid-transfer: an outstanding response is dropped; no rvalid_o is issued for it.
- Register map (word-aligned byte offsets):
  - 0x00 MSIP: bit0 is read/write; bits 31:1 read 0 and ignore writes.
  - 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI.
  - 0x10 MTIME_LO, 0x14 MTIME_HI.
  - All other offsets are unmapped.
- Bus handshake:
  - Slave is always ready; no grant signal.
  - A request in cycle N gets rvalid_o=1 in cycle N+1 for exactly one cycle. Back-to-back requests are allowed, giving one response per cycle.
  - rdata_o returns the register value as it was in cycle N, i.e. before any update made in that cycle.
  - Write responses return rdata_o=0.
- Errors:
  - Triggered by addr_i[1:0]!=0 or an unmapped offset.
  - Response: err_o=1 with rvalid_o, rdata_o=0, no state change.
  - err_o=0 on every other response.
- Writes: honour be_i per byte. be_i=0 completes normally and changes nothing.
- Prescaler:
  - Counter runs 0..PRESCALER-1, then wraps to 0.
  - The tick asserts in the cycle the counter equals PRESCALER-1.
  - With PRESCALER=1, tick is asserted every cycle.
- mtime:
  - Increments by 1 on tick, wrapping from 2^64-1 to 0 with a full 64-bit carry.
  - A bus write to MTIME_LO or MTIME_HI in the same cycle as a tick wins for the written half.
  - In that cycle the other half holds; no increment and no carry is applied.
  - The prescaler keeps running during mtime writes.
- timer_irq_o: registered as (mtime >= mtimecmp), unsigned 64-bit compare of the current registered values. It follows the compare with 1 cycle latency.
  - It deasserts 1 cycle after mtimecmp is written above mtime.
  - It is not latched.
  - A software update of mtimecmp as two 32-bit writes may glitch the interrupt between the writes; software sequencing is responsible for avoiding that.
- sw_irq_o: a direct registered copy of msip bit0, so it changes in the cycle after the write.
- Simultaneous events: the compare uses pre-update values; a bus write and a tick in the same cycle resolve per the mtime rule above.

Decomposition:
- Shared package jedro_1_defines additions:
  - CLINT_ADDR_MSIP, CLINT_ADDR_MTIMECMP_LO/HI, CLINT_ADDR_MTIME_LO/HI.
  - CLINT_MTIMECMP_RST (all ones).
  - CLINT_BUS_BE_WIDTH = 4.
- Sub-module jedro_1_clint_prescaler: parameterised tick generator (counter plus tick output).
- The register file, compare logic and bus logic stay in the top.

Test Plan:
- Reset, then read 0x08/0x0C -> 0xFFFFFFFF/0xFFFFFFFF. Read 0x10 in the first cycle after reset -> 0. timer_irq_o=0 and sw_irq_o=0.
- PRESCALER=4, run 40 cycles, read MTIME_LO -> 10 (±1 allowed only per the documented sample point; the bench computes the exact value). Read rvalid_o exactly 1 cycle after req_i.
- Write MTIMECMP_HI=0, then MTIMECMP_LO=20 with PRESCALER=1 -> timer_irq_o rises the cycle after mtime reaches 20. Write MTIMECMP_LO=0xFFFFFFFF -> timer_irq_o falls 1 cycle later.
- Write MTIME_LO=0xFFFFFFFF, MTIME_HI=0 with PRESCALER=1 -> MTIME_HI reads 1 after the wrap. Write MTIME_LO=5 on a tick cycle -> next read 5, and HI unchanged.
- Write 0x00 with wdata 0xFFFFFFFF, be_i=4'b0001 -> sw_irq_o=1 next cycle; read 0x00 -> 0x00000001. Same write with be_i=4'b0010 -> no change.
- Read 0x04 -> err_o=1, rdata_o=0. Write 0x11 -> err_o=1 and mtime unaffected. Assert rst_i between req_i and rvalid_o -> no response, all outputs 0 asynchronously.
